multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port op, input, 6: IR[31:26], valid from ID onward.
REQ-004 SHALL have port funct, input, 6: IR[5:0], valid from ID onward.
REQ-005 SHALL have port zero, input, 1: ALU result == 0, valid in EX.
REQ-006 SHALL have port mem_ack, input, 1: memory completes current request this cycle.
REQ-007 SHALL have port mem_req, output, 1: memory request, held until mem_ack.
REQ-008 SHALL have port mem_we, output, 1: request is a write (sw only).
REQ-009 SHALL have port ir_wr, pc_wr, output, 1 each: load IR / load PC this cycle.
REQ-010 SHALL have port pc_src, output, 2: 0 PC+4, 1 branch target, 2 jump target, 3 ALU result (jr).
REQ-011 SHALL have port Ctrl_regWr, Ctrl_MemWr, Ctrl_ext, output, 1 each: regfile write, memory write strobe, sign(1)/zero(0) extend.
REQ-012 SHALL have port Ctrl_regDst, Ctrl_aluSrcA, Ctrl_aluSrcB, Ctrl_Mem2Reg, output, 2 each: mux selects (regDst 0 rt/1 rd/2 $31; srcA 0 rs/1 const 16; srcB 0 rt/1 shamt/2 ext imm; Mem2Reg 0 ALU/1 mem/2 PC+4).
REQ-013 SHALL have port Ctrl_alu, output, 5: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL.
REQ-014 SHALL have port state, output, 3: current FSM state; port illegal, output, 1: sticky bad-opcode flag; port retired, output, 32: retired-instruction count.

Function
REQ-015 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
REQ-016 IF SHALL assert mem_req (mem_we=0) each cycle until mem_ack; on mem_ack cycle assert ir_wr, pc_wr, pc_src=0, go to ID; else stay IF.
REQ-017 ID SHALL decode op/funct: j -> pc_wr, pc_src=2, retire, go IF; jal -> pc_wr, pc_src=2, go WB; R-type jr (funct 001000) -> pc_wr, pc_src=3, Ctrl_aluSrcA=0, Ctrl_alu=ADD with srcB=rt masked by retire, go IF; unsupported op/funct -> illegal=1, go HALT; else go EX.
REQ-018 Supported set SHALL be R-type add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000; addi 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-019 EX SHALL drive ALU: R-type srcA=0, srcB=0 (sll srcB=1, srcA=0, Ctrl_alu=SLL); addi/lw/sw ADD, srcB=2, ext=1; ori OR, srcB=2, ext=0; lui SLL, srcA=1, srcB=2, ext=0; beq SUB, srcB=0.
REQ-020 EX for beq SHALL assert pc_wr with pc_src=1 only when zero=1, retire, go IF; lw/sw go MEM; all others go WB.
REQ-021 MEM SHALL hold mem_req=1, mem_we=(sw), Ctrl_MemWr=(sw) until mem_ack; on ack sw retires and goes IF, lw goes WB; EX ALU selects SHALL remain driven throughout MEM.
REQ-022 WB SHALL assert Ctrl_regWr for one cycle: R-type regDst=1, Mem2Reg=0; I-type ALU regDst=0, Mem2Reg=0; lw regDst=0, Mem2Reg=1; jal regDst=2, Mem2Reg=2; retire, go IF.
REQ-023 Outputs not named for a state SHALL be 0 in that state; ir_wr, pc_wr, Ctrl_regWr, Ctrl_MemWr SHALL never assert in HALT.
REQ-024 mem_ack while mem_req=0 SHALL be ignored.
REQ-025 retired SHALL increment by 1 on each retire cycle, wrapping 0xFFFFFFFF -> 0.
REQ-026 Latency (mem_ack same cycle as request): R/I-ALU 4, lw 5, sw 4, beq 3, j 2, jr 2, jal 3 cycles.
REQ-027 HALT SHALL be left only by reset.

Reset
REQ-028 rst=0 at a clock edge SHALL force state=IF, illegal=0, retired=0, all strobes and selects 0, independent of any in-flight request; mem_req SHALL be 0 from the cycle rst is first sampled low until state IF is re-entered after rst returns to 1.

Verification
REQ-029 Reset with mem_ack tied 1, op=0x00 funct=0x20 -> state 0,1,2,4,0; Ctrl_regWr=1, regDst=1 in WB; retired=1 after 4 cycles.
REQ-030 lw (op 0x23), mem_ack low for 3 cycles in MEM -> MEM held 4 cycles, mem_we=0, then WB with Mem2Reg=1; total 8 cycles.
REQ-031 beq (op 0x04) with zero=1 then zero=0 -> pc_wr=1 pc_src=1 in first EX, pc_wr=0 in second; both retire in 3 cycles.
REQ-032 op=0x3F -> illegal=1, state=5, no strobes for 10 cycles; rst low -> state 0, illegal 0.
REQ-033 rst low during MEM of sw -> Ctrl_MemWr and mem_req 0 following edge, retired unchanged by sw, state 0.
REQ-034 jal (op 0x03) -> pc_wr pc_src=2 in ID, WB regDst=2 Mem2Reg=2; preload retired=0xFFFFFFFF via long run -> wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: IF/ID/EX/MEM/WB sequencing, decode,
// mux/strobe generation, sticky illegal-opcode flag and retired counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        Ctrl_regWr,
    output logic        Ctrl_MemWr,
    output logic        Ctrl_ext,
    output logic [1:0]  Ctrl_regDst,
    output logic [1:0]  Ctrl_aluSrcA,
    output logic [1:0]  Ctrl_aluSrcB,
    output logic [1:0]  Ctrl_Mem2Reg,
    output logic [4:0]  Ctrl_alu,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22,
                           F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR = 5'd3,
                           ALU_SLT = 5'd4, ALU_SLL = 5'd5;

    state_t      r_state, w_state_next;
    logic        r_illegal, r_rst_hold;
    logic [31:0] r_retired;
    logic        w_retire, w_set_illegal;

    logic w_rtype, w_r_legal, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_legal;
    assign w_rtype   = (op == OP_R);
    assign w_r_legal = (funct == F_SLL) || (funct == F_JR) || (funct == F_ADD) ||
                       (funct == F_SUB) || (funct == F_AND) || (funct == F_OR) ||
                       (funct == F_SLT);
    assign w_is_jr   = w_rtype && (funct == F_JR);
    assign w_is_lw   = (op == OP_LW);
    assign w_is_sw   = (op == OP_SW);
    assign w_is_beq  = (op == OP_BEQ);
    assign w_legal   = w_rtype ? w_r_legal :
                       ((op == OP_J) || (op == OP_JAL) || w_is_beq || (op == OP_ADDI) ||
                        (op == OP_ORI) || (op == OP_LUI) || w_is_lw || w_is_sw);

    // ALU selects for the EX phase; MEM reuses them so the address stays stable.
    logic [4:0] w_alu;
    logic [1:0] w_src_a, w_src_b;
    logic       w_ext;
    always_comb begin
        w_alu   = ALU_ADD;
        w_src_a = 2'd0;
        w_src_b = 2'd0;
        w_ext   = 1'b0;
        case (op)
            OP_R: begin
                case (funct)
                    F_SUB:   w_alu = ALU_SUB;
                    F_AND:   w_alu = ALU_AND;
                    F_OR:    w_alu = ALU_OR;
                    F_SLT:   w_alu = ALU_SLT;
                    F_SLL: begin
                        w_alu   = ALU_SLL;
                        w_src_b = 2'd1;
                    end
                    default: w_alu = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                w_src_b = 2'd2;
                w_ext   = 1'b1;
            end
            OP_ORI: begin
                w_alu   = ALU_OR;
                w_src_b = 2'd2;
            end
            OP_LUI: begin
                w_alu   = ALU_SLL;
                w_src_a = 2'd1;
                w_src_b = 2'd2;
            end
            OP_BEQ:  w_alu = ALU_SUB;
            default: w_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_retire      = 1'b0;
        w_set_illegal = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_wr         = 1'b0;
        pc_wr         = 1'b0;
        pc_src        = 2'd0;
        Ctrl_regWr    = 1'b0;
        Ctrl_MemWr    = 1'b0;
        Ctrl_ext      = 1'b0;
        Ctrl_regDst   = 2'd0;
        Ctrl_aluSrcA  = 2'd0;
        Ctrl_aluSrcB  = 2'd0;
        Ctrl_Mem2Reg  = 2'd0;
        Ctrl_alu      = 5'd0;
        // Everything stays quiet from the first low-sampled reset edge until IF is live again.
        if (!r_rst_hold) begin
            case (r_state)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_wr        = 1'b1;
                        pc_wr        = 1'b1;
                        w_state_next = S_ID;
                    end
                end
                S_ID: begin
                    if (!w_legal) begin
                        w_set_illegal = 1'b1;
                        w_state_next  = S_HALT;
                    end else if (op == OP_J) begin
                        pc_wr        = 1'b1;
                        pc_src       = 2'd2;
                        w_retire     = 1'b1;
                        w_state_next = S_IF;
                    end else if (op == OP_JAL) begin
                        pc_wr        = 1'b1;
                        pc_src       = 2'd2;
                        w_state_next = S_WB;
                    end else if (w_is_jr) begin
                        pc_wr        = 1'b1;
                        pc_src       = 2'd3;
                        w_retire     = 1'b1;
                        w_state_next = S_IF;
                    end else begin
                        w_state_next = S_EX;
                    end
                end
                S_EX: begin
                    Ctrl_alu     = w_alu;
                    Ctrl_aluSrcA = w_src_a;
                    Ctrl_aluSrcB = w_src_b;
                    Ctrl_ext     = w_ext;
                    if (w_is_beq) begin
                        pc_wr        = zero;
                        pc_src       = zero ? 2'd1 : 2'd0;
                        w_retire     = 1'b1;
                        w_state_next = S_IF;
                    end else if (w_is_lw || w_is_sw) begin
                        w_state_next = S_MEM;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
                S_MEM: begin
                    Ctrl_alu     = w_alu;
                    Ctrl_aluSrcA = w_src_a;
                    Ctrl_aluSrcB = w_src_b;
                    Ctrl_ext     = w_ext;
                    mem_req      = 1'b1;
                    mem_we       = w_is_sw;
                    Ctrl_MemWr   = w_is_sw;
                    if (mem_ack) begin
                        w_retire     = w_is_sw;
                        w_state_next = w_is_sw ? S_IF : S_WB;
                    end
                end
                S_WB: begin
                    Ctrl_regWr   = 1'b1;
                    w_retire     = 1'b1;
                    w_state_next = S_IF;
                    if (op == OP_JAL) begin
                        Ctrl_regDst  = 2'd2;
                        Ctrl_Mem2Reg = 2'd2;
                    end else if (w_rtype) begin
                        Ctrl_regDst  = 2'd1;
                    end else if (w_is_lw) begin
                        Ctrl_Mem2Reg = 2'd1;
                    end
                end
                S_HALT:  w_state_next = S_HALT;
                default: w_state_next = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IF;
            r_illegal  <= 1'b0;
            r_retired  <= 32'd0;
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
            r_state    <= w_state_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_retire)      r_retired <= r_retired + 32'd1;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;
endmodule
